metrics_counter_bank: RTL



---
 rtl/metrics_counter_bank_if.sv | 26 ++
 rtl/metrics_counter_bank.sv | 58 +++++
 2 files changed

// File: rtl/metrics_counter_bank_if.sv
// metrics_counter_bank_if: control/status bundle between the register block and the counter bank
interface metrics_counter_bank_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 64
);
  logic [NUM_CHANNELS-1:0]               en;
  logic [NUM_CHANNELS-1:0]               clear;
  logic [NUM_CHANNELS-1:0]               mode;
  logic [NUM_CHANNELS-1:0]               event_i;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] threshold;
  logic                                  snapshot;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cnt;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] snap_cnt;
  logic                                  snap_valid;
  logic [NUM_CHANNELS-1:0]               overflow;
  logic [NUM_CHANNELS-1:0]               threshold_hit;
  logic                                  irq;
  modport master (
    output en, clear, mode, event_i, threshold, snapshot,
    input  cnt, snap_cnt, snap_valid, overflow, threshold_hit, irq
  );
  modport slave (
    input  en, clear, mode, event_i, threshold, snapshot,
    output cnt, snap_cnt, snap_valid, overflow, threshold_hit, irq
  );
endinterface

// File: rtl/metrics_counter_bank.sv
// metrics_counter_bank: per-channel cycle/event counters with sticky flags, coherent snapshot and irq
module metrics_counter_bank #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter bit SATURATE      = 1'b0
) (
  input logic clk,
  input logic rst_n,
  metrics_counter_bank_if.slave bus
);
  localparam int W = COUNTER_WIDTH;
  logic [W-1:0] cnt_q  [NUM_CHANNELS];
  logic [W-1:0] snap_q [NUM_CHANNELS];
  logic [W-1:0] cnt_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_q, thr_q, ovf_d, thr_d;
  logic snap_valid_q, irq_q;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [W-1:0] cur, nxt, thr;
    logic inc, full, blocked;
    assign cur     = cnt_q[i];
    assign nxt     = cur + 1'b1;
    assign thr     = bus.threshold[i*W +: W];
    assign inc     = bus.en[i] & (~bus.mode[i] | bus.event_i[i]);
    assign full    = &cur;
    assign blocked = SATURATE & full;
    // an increment at all-ones is the wrap in wrap mode and the first blocked one in saturate mode
    assign cnt_d[i] = bus.clear[i] ? '0 : (inc & ~blocked) ? nxt : cur;
    assign ovf_d[i] = ~bus.clear[i] & (ovf_q[i] | (inc & full));
    assign thr_d[i] = ~bus.clear[i] & (thr_q[i] | (inc & ~blocked & (thr != '0) & (nxt == thr)));
    assign bus.cnt[i*W +: W]      = cnt_q[i];
    assign bus.snap_cnt[i*W +: W] = snap_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c]  <= '0;
        snap_q[c] <= '0;
      end
      ovf_q        <= '0;
      thr_q        <= '0;
      snap_valid_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (bus.snapshot) snap_q[c] <= cnt_q[c];
      end
      ovf_q        <= ovf_d;
      thr_q        <= thr_d;
      snap_valid_q <= bus.snapshot;
      irq_q        <= |{ovf_q, thr_q};
    end
  end
  assign bus.overflow      = ovf_q;
  assign bus.threshold_hit = thr_q;
  assign bus.snap_valid    = snap_valid_q;
  assign bus.irq           = irq_q;
endmodule
